// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants and pixel types.
package lenet_pkg;

  localparam int bitwidth    = 32;
  localparam int L1_CHANNELS = 2;
  localparam int L1_DIM      = 28;
  localparam int POOL1_DIM   = L1_DIM / 2;

  typedef logic signed [bitwidth-1:0] pixel_t;
  typedef pixel_t [L1_CHANNELS-1:0]   pixvec_t;

endpackage

// File: rtl/max2_signed.sv
// Combinational two-input signed maximum; ties return the shared value.
module max2_signed
  import lenet_pkg::*;
#(
  parameter int W = bitwidth
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] y_o
);

  assign y_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster pixel stream, one lane per channel.
// Even rows park horizontal maxima in a half-width line buffer; odd rows finish the window.
module maxpool2x2_stream
  import lenet_pkg::L1_CHANNELS, lenet_pkg::L1_DIM;
#(
  parameter int bitwidth = lenet_pkg::bitwidth,
  parameter int CHANNELS = L1_CHANNELS,
  parameter int IN_W     = L1_DIM,
  parameter int IN_H     = L1_DIM
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNELS-1:0][bitwidth-1:0]  in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS-1:0][bitwidth-1:0]  out_data,
  output logic                               out_last
);

  localparam int CW = $clog2(IN_W);
  localparam int RW = $clog2(IN_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CHANNELS-1:0][bitwidth-1:0] hold_q, hold_d;
  logic [CHANNELS-1:0][bitwidth-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;

  logic [CHANNELS-1:0][bitwidth-1:0] linebuf_q [IN_W/2];
  logic [CHANNELS-1:0][bitwidth-1:0] lb_rd, hmax, vmax;
  logic accept, lb_we;

  assign in_ready  = !(out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign lb_rd     = linebuf_q[col_q[CW-1:1]];
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
    max2_signed #(.W(bitwidth)) u_hmax (
      .a_i(hold_q[ch]),
      .b_i(in_data[ch]),
      .y_o(hmax[ch])
    );
    max2_signed #(.W(bitwidth)) u_vmax (
      .a_i(lb_rd[ch]),
      .b_i(hmax[ch]),
      .y_o(vmax[ch])
    );
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    lb_we       = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        // A same-cycle refill overrides the drain above.
        out_valid_d = 1'b1;
        out_data_d  = vmax;
        out_last_d  = (row_q == RW'(IN_H-1)) && (col_q == CW'(IN_W-1));
      end

      if (col_q == CW'(IN_W-1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IN_H-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Contents need no reset: every entry is written on an even row before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[col_q[CW-1:1]] <= hmax;
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: ramp frames, signed window, stalls, gaps, resets.
module tb_maxpool2x2_stream;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0][31:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0][31:0]  out_data;
  logic              out_last;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int last_cnt = 0;
  int base = 0;
  bit exp_sgn = 1'b0;
  int mk, mi, mj, me0, me1;
  int bp_w, lc0, part_base;

  maxpool2x2_stream dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Output monitor: a transfer seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mk  = (out_cnt - base) % 196;
      mi  = mk / 14;
      mj  = mk % 14;
      me0 = (2*mi + 1) * 28 + 2*mj + 1;
      me1 = me0;
      if (exp_sgn && mk == 0) begin
        me0 = -3;
        me1 = 4;
      end
      chk("out_ch0", out_data[0], 32'(me0));
      chk("out_ch1", out_data[1], 32'(me1));
      chk("out_last", {31'b0, out_last}, {31'b0, (mk == 195)});
      if (out_last) last_cnt++;
      out_cnt++;
    end
  end

  function automatic logic [1:0][31:0] pix(input int r, input int c, input bit sgn);
    logic [1:0][31:0] v;
    v[0] = 32'(r*28 + c);
    v[1] = v[0];
    if (sgn && r < 2 && c < 2) begin
      case (r*2 + c)
        0: v[0] = -32'sd5;
        1: v[0] = -32'sd3;
        2: v[0] = -32'sd9;
        default: v[0] = -32'sd7;
      endcase
      v[1] = 32'd4;
    end
    return v;
  endfunction

  task automatic send_beat(input logic [1:0][31:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      checks++;
      errors++;
      $error("FAIL in_ready_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit sgn, input bit gaps, input int nbeats);
    int n = 0;
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        if (n < nbeats) begin
          if (gaps && ($urandom_range(1, 0) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send_beat(pix(r, c, sgn));
          n++;
        end
      end
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_out_data0", out_data[0], 32'd0);
    chk("rst_out_data1", out_data[1], 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Plain ramp frame
    base = out_cnt;
    lc0  = last_cnt;
    send_frame(1'b0, 1'b0, 784);
    drain();
    chk("ramp_count", 32'(out_cnt - base), 32'd196);
    chk("ramp_last_count", 32'(last_cnt - lc0), 32'd1);

    // Negative window on channel 0, flat window on channel 1
    base    = out_cnt;
    exp_sgn = 1'b1;
    send_frame(1'b1, 1'b0, 784);
    drain();
    exp_sgn = 1'b0;
    chk("signed_count", 32'(out_cnt - base), 32'd196);

    // Backpressure from the first output onwards
    base      = out_cnt;
    out_ready = 1'b0;
    fork
      send_frame(1'b0, 1'b0, 784);
      begin
        bp_w = 0;
        @(negedge clk);
        while (!out_valid && bp_w < 200) begin
          @(negedge clk);
          bp_w++;
        end
        chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
          chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
          chk("bp_out_data", out_data[0], 32'd29);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(out_cnt - base), 32'd196);

    // Random input gaps
    base = out_cnt;
    send_frame(1'b0, 1'b1, 784);
    drain();
    chk("gap_count", 32'(out_cnt - base), 32'd196);

    // Reset in the middle of row 17; the output registered by the last beat is dropped
    base      = out_cnt;
    part_base = out_cnt;
    send_frame(1'b0, 1'b0, 17*28 + 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data[0], 32'd0);
    chk("partial_count", 32'(out_cnt - part_base), 32'd116);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = out_cnt;
    send_frame(1'b0, 1'b0, 784);
    drain();
    chk("postrst_count", 32'(out_cnt - base), 32'd196);

    // Two frames back to back
    base = out_cnt;
    lc0  = last_cnt;
    send_frame(1'b0, 1'b0, 784);
    send_frame(1'b0, 1'b0, 784);
    drain();
    chk("b2b_count", 32'(out_cnt - base), 32'd392);
    chk("b2b_last_count", 32'(last_cnt - lc0), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
